// File: rtl/bfu_mul_arbiter.sv
// Shares one bfu_multiplier between the NTT butterfly (port 0) and the pointwise unit (port 1).
// Round-robin issue, a latency-matched tag pipeline, and credit-protected response FIFOs.
module bfu_mul_arbiter #(
    parameter int MUL_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_selKD_i,
    input  logic [31:0] req0_srcA_i,
    input  logic [31:0] req0_srcB_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_selKD_i,
    input  logic [31:0] req1_srcA_i,
    input  logic [31:0] req1_srcB_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [63:0] rsp0_result_o,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [63:0] rsp1_result_o,
    output logic        mul_validSrc_o,
    output logic        mul_selKD_o,
    output logic [31:0] mul_srcA_o,
    output logic [31:0] mul_srcB_o,
    output logic        mul_flush_o,
    input  logic        mul_validResult_i,
    input  logic [63:0] mul_result_i,
    output logic        err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       hs;
    logic [1:0][63:0] rsp_data;
    logic             last_grant;
    logic [MUL_LATENCY:0] tag_v;
    logic [MUL_LATENCY:0] tag_id;
    logic             tag_out_v;
    logic             tag_out_id;

    assign req_valid  = {req1_valid_i, req0_valid_i};
    assign rsp_ready  = {rsp1_ready_i, rsp0_ready_i};
    assign tag_out_v  = tag_v[MUL_LATENCY];
    assign tag_out_id = tag_id[MUL_LATENCY];

    // Contention goes to the port that did not win the last accepted handshake.
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        hs = grant & {2{~flush_i}};
    end

    assign req0_ready_o  = hs[0];
    assign req1_ready_o  = hs[1];
    assign rsp0_valid_o  = rsp_valid[0];
    assign rsp1_valid_o  = rsp_valid[1];
    assign rsp0_result_o = rsp_data[0];
    assign rsp1_result_o = rsp_data[1];
    assign mul_flush_o   = flush_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_grant <= 1'b1;
        end else if (hs[1]) begin
            last_grant <= 1'b1;
        end else if (hs[0]) begin
            last_grant <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mul_validSrc_o <= 1'b0;
            mul_selKD_o    <= 1'b0;
            mul_srcA_o     <= '0;
            mul_srcB_o     <= '0;
        end else begin
            mul_validSrc_o <= |hs;
            if (hs[0]) begin
                mul_selKD_o <= req0_selKD_i;
                mul_srcA_o  <= req0_srcA_i;
                mul_srcB_o  <= req0_srcB_i;
            end else if (hs[1]) begin
                mul_selKD_o <= req1_selKD_i;
                mul_srcA_o  <= req1_srcA_i;
                mul_srcB_o  <= req1_srcB_i;
            end
        end
    end

    // Stage 0 lines up with mul_validSrc_o, so the last stage lines up with the result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= flush_i ? '0 : {tag_v[MUL_LATENCY-1:0], |hs};
            tag_id <= {tag_id[MUL_LATENCY-1:0], hs[1]};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_o <= 1'b0;
        end else if (tag_out_v && !mul_validResult_i && !flush_i) begin
            err_o <= 1'b1;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [CW-1:0] inflight;
        logic [AW:0]   wptr;
        logic [AW:0]   rptr;
        logic [AW:0]   occ;
        logic [63:0]   mem [FIFO_DEPTH];
        logic          retire;
        logic          fifo_wr;
        logic          fifo_rd;

        // A slot is reserved at issue, so occupancy plus in-flight never exceeds the FIFO.
        assign occ         = wptr - rptr;
        assign eligible[p] = req_valid[p] && (({1'b0, occ} + {1'b0, inflight}) < DEPTH_C);
        assign retire      = tag_out_v && (tag_out_id == 1'(p)) && !flush_i;
        assign fifo_wr     = retire && mul_validResult_i;
        assign rsp_valid[p] = (occ != '0);
        assign fifo_rd     = rsp_valid[p] && rsp_ready[p];
        assign rsp_data[p] = mem[rptr[AW-1:0]];

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                inflight <= '0;
            end else if (flush_i) begin
                inflight <= '0;
            end else if (hs[p] && !retire) begin
                inflight <= inflight + CNT_ONE;
            end else if (!hs[p] && retire) begin
                inflight <= inflight - CNT_ONE;
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                wptr <= '0;
                rptr <= '0;
            end else if (flush_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (fifo_wr) wptr <= wptr + PTR_ONE;
                if (fifo_rd) rptr <= rptr + PTR_ONE;
            end
        end

        always_ff @(posedge clk_i) begin
            if (fifo_wr) begin
                mem[wptr[AW-1:0]] <= mul_result_i;
            end
        end
    end

endmodule
